mem_line_responder: RTL and testbench

- Main-memory side of the cache refill/writeback interface.
- Accepts whole-line read and write requests from the data cache in the memory stage, models a fixed access latency, then returns the read line or commits the written line.
- Signals completion with a one-cycle grant pulse.
- Sits below the cache and replaces the cache's internal memory model, so bench and FPGA builds share one responder.

---
 rtl/mem_line_responder_pkg.sv | 34 +++
 rtl/mem_line_responder_array.sv | 42 ++++
 rtl/mem_line_responder.sv | 142 ++++++++++++++
 tb/tb_mem_line_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_responder_pkg.sv
// Shared definitions for the cache line refill/writeback interface.
// The data cache and the memory-side responder both import this package,
// so they use one state encoding, one op encoding and one line geometry.
//   LINE_ADDR_LEN  log2 of 32-bit words per line (default geometry)
//   LINE_WORDS     words per line
//   LINE_BITS      width of a whole line in bits
//   state_t        responder FSM encoding (IDLE, BUSY, GRANT)
//   op_t           operation in flight (OP_RD, OP_WR)
package mem_line_responder_pkg;

  localparam int WORD_BITS     = 32;
  localparam int LINE_ADDR_LEN = 2;
  localparam int LINE_WORDS    = 1 << LINE_ADDR_LEN;
  localparam int LINE_BITS     = WORD_BITS * LINE_WORDS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    GRANT = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Latency counter width: it must hold max(rd, wr) - 1 with one bit of headroom.
  function automatic int cnt_width(input int rd_cycle, input int wr_cycle);
    int m;
    m = (rd_cycle > wr_cycle) ? rd_cycle : wr_cycle;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mem_line_responder_array.sv
// mem_line_array: synchronous single-port line-wide RAM.
//   clk    clock
//   rst    asynchronous active-high reset; clears only the read register
//   en     access strobe
//   we     1 = write wdata to mem[addr], 0 = read mem[addr] into rdata
//   addr   line address
//   wdata  line to write
//   rdata  registered read line; holds until the next read access
// The storage itself is never reset, so its contents survive a reset of
// the responder.
module mem_line_array
  import mem_line_responder_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = LINE_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: main-memory side of the cache refill/writeback port.
// Accepts whole-line reads and writes, waits a fixed latency, then reads or
// commits the line and pulses gnt for one cycle.
//   clk      clock
//   rst      asynchronous active-high reset (aborts any op in flight)
//   addr     line address of the request
//   rd_req   line read request, held until gnt is sampled
//   wr_req   line write request, held until gnt is sampled (wins over rd_req)
//   wr_line  line to write, word 0 in bits [31:0]
//   rd_line  read line, valid from the gnt cycle, held until the next read grant
//   gnt      one-cycle completion pulse
//   busy     high from the accept edge through the gnt cycle
//   rd_cnt   completed reads (wraps)
//   wr_cnt   completed writes (wraps)
// RD_CYCLE and WR_CYCLE must both be >= 1.
//
// state | meaning
// IDLE  | waiting for a request; write wins over read
// BUSY  | latency countdown, inputs ignored
// GRANT | gnt pulse; RAM access happened on the edge into this state
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int LINE_ADDR_LEN = 2,
  parameter int MEM_ADDR_LEN  = 11,
  parameter int RD_CYCLE      = 50,
  parameter int WR_CYCLE      = 50
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [MEM_ADDR_LEN-1:0]                 addr,
  input  logic                                    rd_req,
  input  logic                                    wr_req,
  input  logic [WORD_BITS*(2**LINE_ADDR_LEN)-1:0] wr_line,
  output logic [WORD_BITS*(2**LINE_ADDR_LEN)-1:0] rd_line,
  output logic                                    gnt,
  output logic                                    busy,
  output logic [31:0]                             rd_cnt,
  output logic [31:0]                             wr_cnt
);

  localparam int LINE_W = WORD_BITS * (2**LINE_ADDR_LEN);
  localparam int CNT_W  = cnt_width(RD_CYCLE, WR_CYCLE);

  // The accept edge itself is the first latency cycle, hence the -1.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLE - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLE - 1);

  state_t                  state;
  state_t                  state_nxt;
  op_t                     op;
  logic [MEM_ADDR_LEN-1:0] addr_q;
  logic [LINE_W-1:0]       line_q;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_done;
  logic                    mem_fire;

  assign cnt_done = (cnt == '0);
  // The RAM is touched only on the BUSY->GRANT edge; an abort before then
  // leaves the array untouched.
  assign mem_fire = (state == BUSY) && cnt_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_RD;
      addr_q <= '0;
      line_q <= '0;
      cnt    <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (wr_req) begin
            op     <= OP_WR;
            addr_q <= addr;
            line_q <= wr_line;
            cnt    <= WR_LOAD;
          end else if (rd_req) begin
            op     <= OP_RD;
            addr_q <= addr;
            cnt    <= RD_LOAD;
          end
        end
        BUSY: begin
          if (!cnt_done) begin
            cnt <= cnt - 1'b1;
          end else if (op == OP_WR) begin
            wr_cnt <= wr_cnt + 32'd1;
          end else begin
            rd_cnt <= rd_cnt + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    gnt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_req || rd_req) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_done) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        busy      = 1'b1;
        gnt       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  mem_line_array #(
    .ADDR_W (MEM_ADDR_LEN),
    .DATA_W (LINE_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_fire),
    .we    (op == OP_WR),
    .addr  (addr_q),
    .wdata (line_q),
    .rdata (rd_line)
  );

endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;

  logic         clk;
  logic         rst;
  logic [10:0]  addr    [2];
  logic [1:0]   rd_req;
  logic [1:0]   wr_req;
  logic [127:0] wr_line [2];
  logic [127:0] rd_line [2];
  logic [1:0]   gnt;
  logic [1:0]   busy;
  logic [31:0]  rd_cnt  [2];
  logic [31:0]  wr_cnt  [2];

  int total = 0;
  int bad   = 0;

  // reference model: per-instance latencies, line store, expected outputs
  int           rdc [2] = '{4, 1};
  int           wrc [2] = '{3, 1};
  logic [127:0] mdl [int];
  logic [127:0] exp_line [2];
  int unsigned  erc [2];
  int unsigned  ewc [2];

  mem_line_responder #(.LINE_ADDR_LEN(2), .MEM_ADDR_LEN(11), .RD_CYCLE(4), .WR_CYCLE(3)) dut0 (
    .clk(clk), .rst(rst), .addr(addr[0]), .rd_req(rd_req[0]), .wr_req(wr_req[0]),
    .wr_line(wr_line[0]), .rd_line(rd_line[0]), .gnt(gnt[0]), .busy(busy[0]),
    .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));

  mem_line_responder #(.LINE_ADDR_LEN(2), .MEM_ADDR_LEN(11), .RD_CYCLE(1), .WR_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .addr(addr[1]), .rd_req(rd_req[1]), .wr_req(wr_req[1]),
    .wr_line(wr_line[1]), .rd_line(rd_line[1]), .gnt(gnt[1]), .busy(busy[1]),
    .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      erc[i] = 0;
      ewc[i] = 0;
      exp_line[i] = '0;
    end
  endtask

  task automatic chk_counts(input int d, input string tag);
    chk({tag, "_rd_cnt"}, rd_cnt[d], erc[d]);
    chk({tag, "_wr_cnt"}, wr_cnt[d], ewc[d]);
  endtask

  // Entered at a negedge with the DUT idle; the request is accepted on the
  // next rising edge. gnt is required in the cycle after accept edge + N.
  task automatic do_op(input int d, input bit is_wr, input logic [10:0] a,
                       input logic [127:0] line, input bit chg, input logic [10:0] a2,
                       input string tag);
    int n;
    int key;
    bit got;
    n   = is_wr ? wrc[d] : rdc[d];
    key = d * 4096 + int'(a);
    got = 1'b0;
    addr[d]    = a;
    wr_line[d] = line;
    if (is_wr) wr_req[d] = 1'b1;
    else       rd_req[d] = 1'b1;
    for (int k = 1; k <= n + 5 && !got; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (chg && k == 1) addr[d] = a2;
      if (gnt[d]) begin
        got = 1'b1;
        chk({tag, "_latency"}, k, n + 1);
        chk({tag, "_busy_gnt"}, busy[d], 1'b1);
        if (is_wr) begin
          mdl[key] = line;
          ewc[d]++;
          wr_req[d] = 1'b0;
        end else begin
          exp_line[d] = mdl[key];
          erc[d]++;
          rd_req[d] = 1'b0;
        end
        chk({tag, "_rd_line"}, rd_line[d], exp_line[d]);
      end else begin
        chk({tag, "_busy"}, busy[d], 1'b1);
        chk({tag, "_line_held"}, rd_line[d], exp_line[d]);
      end
    end
    if (!got) begin
      chk({tag, "_gnt_timeout"}, 1'b0, 1'b1);
      wr_req[d] = 1'b0;
      rd_req[d] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_gnt_one_cycle"}, gnt[d], 1'b0);
    chk_counts(d, tag);
  endtask

  initial begin
    logic [127:0] l1, l2, old20, new20, dead, l33, rl;
    logic [10:0]  ra;
    int           ops;

    rst = 1'b1;
    rd_req = '0;
    wr_req = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      wr_line[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt", gnt[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_rd_line", rd_line[i], '0);
      chk_counts(i, "rst");
    end
    rst = 1'b0;
    @(negedge clk);

    // preload through the write port, then reset so counts start at zero
    l1    = {$urandom, $urandom, $urandom, $urandom};
    l2    = {$urandom, $urandom, $urandom, $urandom};
    old20 = {$urandom, $urandom, $urandom, $urandom};
    new20 = ~old20;
    dead  = {4{32'hDEADBEEF}};
    do_op(0, 1'b1, 11'h005, 128'h00000004_00000003_00000002_00000001, 1'b0, '0, "pre5");
    do_op(0, 1'b1, 11'h001, l1, 1'b0, '0, "pre1");
    do_op(0, 1'b1, 11'h002, l2, 1'b0, '0, "pre2");
    do_op(0, 1'b1, 11'h020, old20, 1'b0, '0, "pre20");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_counts(0, "post_rst");

    // read of preloaded line 5, 4-cycle latency
    do_op(0, 1'b0, 11'h005, '0, 1'b0, '0, "rd5");
    chk("rd5_value", rd_line[0], 128'h00000004_00000003_00000002_00000001);

    // write then read top address
    do_op(0, 1'b1, 11'h7FF, dead, 1'b0, '0, "wr7ff");
    do_op(0, 1'b0, 11'h7FF, '0, 1'b0, '0, "rd7ff");
    chk("rd7ff_value", rd_line[0], dead);

    // simultaneous requests: write first, read left pending returns new data
    rd_req[0] = 1'b1;
    do_op(0, 1'b1, 11'h010, l2 ^ l1, 1'b0, '0, "sim_wr");
    chk("sim_rd_pending", rd_req[0], 1'b1);
    do_op(0, 1'b0, 11'h010, '0, 1'b0, '0, "sim_rd");
    chk("sim_rd_value", rd_line[0], l2 ^ l1);

    // address changed while busy does not redirect the read
    do_op(0, 1'b0, 11'h001, '0, 1'b1, 11'h002, "addr_chg");
    chk("addr_chg_value", rd_line[0], l1);

    // asynchronous reset in the middle of a write
    addr[0]    = 11'h020;
    wr_line[0] = new20;
    wr_req[0]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt", gnt[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_rd_line", rd_line[0], '0);
    wr_req[0] = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_gnt", gnt[0], 1'b0);
    end
    chk_counts(0, "abort");
    do_op(0, 1'b0, 11'h020, '0, 1'b0, '0, "abort_rd");
    chk("abort_old_data", rd_line[0], old20);

    // latency-1 instance: held read yields a grant every third cycle
    l33 = {$urandom, $urandom, $urandom, $urandom};
    do_op(1, 1'b1, 11'h033, l33, 1'b0, '0, "b2b_wr");
    addr[1]   = 11'h033;
    rd_req[1] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b_gnt_pattern", gnt[1], (k % 3) == 2);
      if (gnt[1]) chk("b2b_rd_line", rd_line[1], l33);
    end
    rd_req[1] = 1'b0;
    erc[1] += 4;
    exp_line[1] = l33;
    @(posedge clk);
    @(negedge clk);
    chk_counts(1, "b2b");

    // randomized traffic on both instances against the line store model
    for (int d = 0; d < 2; d++) begin
      for (ops = 0; ops < 25; ops++) begin
        ra = 11'h100 + 11'($urandom_range(0, 7));
        rl = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 0 && mdl.exists(d * 4096 + int'(ra)))
          do_op(d, 1'b0, ra, '0, 1'b0, '0, "rand_rd");
        else
          do_op(d, 1'b1, ra, rl, 1'b0, '0, "rand_wr");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
